// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
// Holds the FSM state encoding, the digit width and the digit range check.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd2bin_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic logic bcd_digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 when the digit is 8 or more.
// Purely combinational, zero latency, no flow control.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  // Only applied from 8 upward, so the 4-bit subtraction cannot wrap.
  assign adj = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Result after BIN_W clocks (invalid digits: straight to DONE); no new input until the result is taken.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [BIN_W-1:0]              bin_o,
  output logic                          err_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i
);

  localparam int BCD_W = DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  bcd2bin_state_t state, state_nxt;

  logic [BCD_W-1:0]       bcd_reg;
  logic [BIN_W-1:0]       bin_reg;
  logic [CNT_W-1:0]       cnt;
  logic                   err_reg;
  logic                   in_bad;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_adj;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      in_bad = in_bad | bcd_digit_invalid(bcd_i[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end
  end

  // The bcd LSB falls into the bin MSB; digits are corrected after the shift.
  assign shifted = {bcd_reg, bin_reg} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_nxt = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            bcd_reg <= in_bad ? '0 : bcd_i;
            bin_reg <= '0;
            err_reg <= in_bad;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= shifted[BIN_W-1:0];
          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bin_o = bin_reg;
  assign err_o = err_reg;

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

- Sequential BCD-to-binary decoder: the reverse of the version-print path's binary-to-BCD encoder.
- Accepts a packed vector of BCD digits, for example from a decimal entry or parameter UI in the synthesizer front panel.
- Converts it with reverse double-dabble (shift right, subtract 3 from any digit ≥ 8), one bit per clock.
- Sits between the user-input/parameter logic and the binary-valued synth control registers, with valid/ready handshakes on both sides.

## Interface

- `DIGITS`, default 3: number of BCD digits accepted.
- `BIN_W`, default 10: output width. Must satisfy 2^BIN_W ≥ 10^DIGITS; the default covers 0..999.
- `clk_i`, input, 1: single clock.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `bcd_i`, input, DIGITS*4: digits, least-significant digit in [3:0].
- `in_valid_i`, input, 1: `bcd_i` is valid.
- `in_ready_o`, output, 1: block can accept a new value.
- `bin_o`, output, BIN_W: conversion result.
- `err_o`, output, 1: the accepted input contained a digit > 9.
- `out_valid_o`, output, 1: `bin_o` and `err_o` are valid.
- `out_ready_i`, input, 1: downstream accepts the result.

## Operation

- Three-state FSM:
  - IDLE: `in_ready_o`=1.
  - SHIFT: conversion running.
  - DONE: `out_valid_o`=1.
- IDLE → SHIFT on `in_valid_i` & `in_ready_o`.
  - Loads the working register {bcd_reg[DIGITS*4], bin_reg[BIN_W]} with {`bcd_i`, 0}.
  - Clears the iteration counter.
- IDLE → DONE instead when any digit of `bcd_i` is > 9 (10..15).
  - Sets err=1 and bin=0; no iterations are performed.
- SHIFT iteration, one per clock:
  - Shift the whole register right by 1. The LSB of bcd_reg enters the MSB of bin_reg.
  - Then, for each digit of the shifted bcd_reg, subtract 3 if the digit is ≥ 8.
  - Both steps are combinational within one cycle.
- SHIFT → DONE after iteration BIN_W. Counter width is clog2(BIN_W+1).
- DONE:
  - `bin_o` = bin_reg.
  - Outputs are held stable until `out_valid_o` & `out_ready_i`, then the FSM returns to IDLE.
- No input is accepted in SHIFT or DONE (`in_ready_o`=0). `bcd_i` changes during SHIFT have no effect.
- All arithmetic is unsigned. The digit adjust operates on 4 bits and never underflows, because it is applied only when the digit is ≥ 8.
- Reset values: FSM=IDLE, `in_ready_o`=1, `out_valid_o`=0, `bin_o`=0, `err_o`=0, working register=0, counter=0.

## Timing

- Latency from the accepting edge to `out_valid_o` high: BIN_W cycles for valid input (10 by default), 1 cycle for invalid input.
- Throughput: one conversion per BIN_W+2 cycles when `out_ready_i` is held high.
- `out_valid_o` and `in_ready_o` are never high in the same cycle.
- If `out_ready_i` is high on the first DONE cycle, the FSM returns to IDLE on the next edge. `in_ready_o` is high the cycle after that handshake.
- Reset asserted mid-SHIFT or in DONE:
  - All state returns to reset values immediately (asynchronously).
  - The pending result is discarded, and no `out_valid_o` pulse is produced after reset releases.
- `in_valid_i` held high through a conversion does not cause a second acceptance until IDLE is reached.

## Structure

- Package `bcd_pkg`:
  - State enum `bcd2bin_state_t` {IDLE, SHIFT, DONE}.
  - Constant `BCD_DIGIT_W`=4.
  - Function `bcd_digit_invalid(logic [3:0])` returning digit > 9.
- Sub-module `bcd_digit_adj`: 4-bit combinational "subtract 3 if ≥ 8", instantiated DIGITS times in a generate loop.
- Top: FSM, counter, and working register only.

## Test plan

- Reset, then `bcd_i`=12'h000 -> `bin_o`=0, `err_o`=0, `out_valid_o` exactly 10 cycles after acceptance.
- `bcd_i`=12'h123 -> `bin_o`=10'd123 (0x07B); then 12'h999 -> 10'd999; then 12'h256 -> 10'd256.
- `bcd_i`=12'h9A5 -> `err_o`=1, `bin_o`=0, `out_valid_o` 1 cycle after acceptance.
- `out_ready_i` held low 5 cycles in DONE -> `bin_o` and `out_valid_o` stable, `in_ready_o`=0 throughout; a new `in_valid_i` pulse in that window is ignored.
- `rst_n_i` pulsed low 4 cycles into a conversion of 12'h777 -> all outputs go to reset values with no clock edge required, and no result appears afterwards; the next conversion of 12'h042 yields 10'd42.
- Exhaustive sweep 000..999, back-to-back with `out_ready_i`=1 -> every result matches the reference model, with a period of BIN_W+2 cycles.
